// File: rtl/sum_accum_pkg.sv
// Shared state encoding and parameter defaults for the frame sum accumulator.
package sum_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int COUNT_DEF  = 4;
  localparam int CNT_W      = 8;

endpackage

// File: rtl/sum_accum_sat_add.sv
// Unsigned saturating adder: clamps to all ones when the sum overflows ACC_W bits.
module sat_add #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  logic [ACC_W:0] sum_ext_s;

  // Widen by one bit so the carry-out is the overflow indicator.
  always_comb begin
    sum_ext_s = {1'b0, a} + {1'b0, b};
    sat       = sum_ext_s[ACC_W];
    if (sum_ext_s[ACC_W]) begin
      sum = {ACC_W{1'b1}};
    end else begin
      sum = sum_ext_s[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/sum_accum.sv
// Accumulates COUNT carry-extended samples into a saturating frame total and
// presents it with a valid/ready handshake.
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int COUNT  = COUNT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_sat
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [ACC_W-1:0] operand_s;
  logic [ACC_W-1:0] add_sum_s;
  logic             add_sat_s;
  logic             accept_s;
  logic             handshake_s;

  assign operand_s   = ACC_W'({in_carry, in_data});
  assign accept_s    = in_valid & in_ready_q;
  assign handshake_s = out_valid_q & out_ready;

  sat_add #(
    .ACC_W(ACC_W)
  ) u_sat_add (
    .a  (acc_q),
    .b  (operand_s),
    .sum(add_sum_s),
    .sat(add_sat_s)
  );

  // Next-state logic; clear overrides both accept and the result handshake.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      state_d     = ACCUM;
      acc_d       = {ACC_W{1'b0}};
      cnt_d       = {CNT_W{1'b0}};
      sat_d       = 1'b0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept_s) begin
            acc_d = add_sum_s;
            sat_d = sat_q | add_sat_s;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == LAST_CNT) begin
              state_d     = HOLD;
              in_ready_d  = 1'b0;
              out_valid_d = 1'b1;
            end else begin
              state_d = ACCUM;
            end
          end else begin
            state_d = ACCUM;
          end
        end
        HOLD: begin
          if (handshake_s) begin
            state_d     = ACCUM;
            acc_d       = {ACC_W{1'b0}};
            cnt_d       = {CNT_W{1'b0}};
            sat_d       = 1'b0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d     = ACCUM;
          acc_d       = {ACC_W{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
          sat_d       = 1'b0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered handshake outputs; reset discards any pending frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_sum_accum.sv
// Directed bench for sum_accum: default instance plus an ACC_W=10 instance
// fed the same stimulus so saturation can be observed on identical frames.
module tb_sum_accum;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_carry;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_sum;
  logic        out_sat;

  logic        in_ready10;
  logic        out_valid10;
  logic [9:0]  out_sum10;
  logic        out_sat10;

  int n_checks;
  int n_errors;

  sum_accum dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_carry (in_carry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_sat  (out_sat)
  );

  sum_accum #(.DATA_W(8), .ACC_W(10), .COUNT(4)) dut10 (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready10),
    .in_data  (in_data),
    .in_carry (in_carry),
    .out_valid(out_valid10),
    .out_ready(out_ready),
    .out_sum  (out_sum10),
    .out_sat  (out_sat10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample for exactly one edge, leave time 1 unit after that edge.
  task automatic push(input logic c, input logic [7:0] d);
    in_carry = c;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_carry  = 1'b0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    rst = 1'b0;

    // Basic frame 10+20+30+40, accepted from the first edge after reset.
    push(1'b0, 8'd10);
    check("f1_live_sum", 32'(out_sum), 32'd10);
    push(1'b0, 8'd20);
    push(1'b0, 8'd30);
    check("f1_valid_early", 32'(out_valid), 32'd0);
    push(1'b0, 8'd40);
    check("f1_valid", 32'(out_valid), 32'd1);
    check("f1_sum", 32'(out_sum), 32'd100);
    check("f1_sat", 32'(out_sat), 32'd0);
    check("f1_in_ready", 32'(in_ready), 32'd0);
    tick;
    check("f1_release_valid", 32'(out_valid), 32'd0);
    check("f1_release_ready", 32'(in_ready), 32'd1);
    check("f1_release_sum", 32'(out_sum), 32'd0);

    // Carry bit forms operand 511; ACC_W=10 instance saturates on the same frame.
    push(1'b1, 8'd255);
    check("f2_carry_operand", 32'(out_sum), 32'd511);
    for (int i = 0; i < 3; i++) push(1'b1, 8'd255);
    check("f2_valid", 32'(out_valid), 32'd1);
    check("f2_sum", 32'(out_sum), 32'd2044);
    check("f2_sat", 32'(out_sat), 32'd0);
    check("f2_w10_valid", 32'(out_valid10), 32'd1);
    check("f2_w10_sum", 32'(out_sum10), 32'd1023);
    check("f2_w10_sat", 32'(out_sat10), 32'd1);
    tick;
    for (int i = 0; i < 4; i++) push(1'b0, 8'd1);
    check("f3_sum", 32'(out_sum), 32'd4);
    check("f3_w10_sum", 32'(out_sum10), 32'd4);
    check("f3_w10_sat", 32'(out_sat10), 32'd0);
    tick;

    // Backpressure: result held for 5 cycles while in_valid pulses are ignored.
    out_ready = 1'b0;
    push(1'b0, 8'd1);
    push(1'b0, 8'd2);
    push(1'b0, 8'd3);
    push(1'b0, 8'd4);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 8'd99;
      tick;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(out_sum), 32'd10);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_sum", 32'(out_sum), 32'd0);

    // Clear mid-frame drops the pending sample and restarts the count.
    push(1'b0, 8'd7);
    push(1'b0, 8'd8);
    check("clr_pre_sum", 32'(out_sum), 32'd15);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd9;
    tick;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_sum", 32'(out_sum), 32'd0);
    push(1'b0, 8'd5);
    push(1'b0, 8'd5);
    push(1'b0, 8'd5);
    check("clr_count_restart", 32'(out_valid), 32'd0);
    push(1'b0, 8'd5);
    check("clr_frame_valid", 32'(out_valid), 32'd1);
    check("clr_frame_sum", 32'(out_sum), 32'd20);

    // Clear during the handshake cycle wins: frame discarded, no stale result.
    clear = 1'b1;
    tick;
    clear = 1'b0;
    check("clr_hs_valid", 32'(out_valid), 32'd0);
    check("clr_hs_sum", 32'(out_sum), 32'd0);
    check("clr_hs_ready", 32'(in_ready), 32'd1);

    // COUNT-th accept must still be needed after the clear.
    for (int i = 0; i < 3; i++) push(1'b0, 8'd2);
    check("post_clr_count", 32'(out_valid), 32'd0);
    push(1'b0, 8'd2);
    check("post_clr_sum", 32'(out_sum), 32'd8);

    // Async reset while holding a result.
    out_ready = 1'b0;
    tick;
    check("hold_before_rst", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_sum", 32'(out_sum), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    push(1'b0, 8'd3);
    check("post_rst_first_accept", 32'(out_sum), 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
